sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single user port of the SP8 SDRAM controller between two requesters: PRG (CPU side, read/write) and CHR (PPU side, read-only).
- Sits between the cart mapper logic and the SDRAM controller, in the clk_mem domain.
- Holds both requesters off until the controller completes EEPROM-to-SDRAM initialisation.
- Relocates CHR addresses to a fixed SDRAM base, arbitrates round-robin and returns per-port read data.

Parameters:
- ADDR_W, 21, SDRAM byte address width (matches controller mem_address).
- PRG_AW, 15, PRG requester address width.
- CHR_AW, 13, CHR requester address width.
- CHR_BASE, 21'h08000, SDRAM offset added to CHR addresses.

Ports:
- clk  input  1  memory clock (clk_mem).
- rst_n  input  1  asynchronous active-low reset.
- prg_req  input  1  PRG request, level, held until prg_ack.
- prg_wren  input  1  PRG write when 1, read when 0; sampled with prg_req.
- prg_addr  input  PRG_AW  PRG byte address.
- prg_wdata  input  8  PRG write data.
- prg_rdata  output  8  PRG read data, valid from prg_ack onward.
- prg_ack  output  1  one-cycle completion pulse.
- chr_req  input  1  CHR read request, level, held until chr_ack.
- chr_addr  input  CHR_AW  CHR byte address.
- chr_rdata  output  8  CHR read data, valid from chr_ack onward.
- chr_ack  output  1  one-cycle completion pulse.
- mem_address  output  ADDR_W  to controller.
- to_mem  output  8  to controller.
- from_mem  input  8  from controller.
- mem_req  output  1  one-cycle request strobe to controller.
- mem_wren  output  1  to controller.
- mem_ready  input  1  controller idle/done.
- init_done  output  1  high once the controller has first reported ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State INIT.
  - All outputs 0, including mem_address, to_mem, rdata registers and init_done.
  - last_grant = CHR, so PRG wins the first tie.
- Controller contract:
  - mem_req is only pulsed while mem_ready = 1.
  - The controller drops mem_ready within 2 cycles of mem_req and raises it again when the access is done.
  - On a read, from_mem is valid in the first cycle mem_ready is high again.
- States:
  - INIT: wait for mem_ready = 1, then set init_done <= 1 and go to IDLE. Requests are ignored and not acknowledged; they remain pending.
  - IDLE: if no request, stay. If exactly one request, grant it. If both, grant the port opposite last_grant (round-robin). On grant, register mem_address, mem_wren and to_mem, pulse mem_req for 1 cycle, and go to BUSY_WAIT_LOW.
  - BUSY_WAIT_LOW: wait for mem_ready = 0, then go to BUSY.
  - BUSY: on mem_ready = 1, latch from_mem into the granted port's rdata (reads only), pulse its ack, update last_grant, and return to IDLE.
- Address mapping:
  - PRG: mem_address = zero-extended prg_addr.
  - CHR: mem_address = CHR_BASE + zero-extended chr_addr, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - mem_wren is 0 for every CHR grant.
- Latency: an uncontended request gets its ack exactly 1 cycle after the controller raises mem_ready. The minimum is mem_req + 3 cycles.
- Held signals:
  - mem_address, mem_wren and to_mem hold stable from mem_req until the ack.
  - rdata holds its value until that port's next read completes; PRG writes do not alter prg_rdata.
- Back-to-back: a requester must drop its req in the cycle after its ack. A req still high 1 cycle after the ack counts as a new request.
- Simultaneous events: a new request arriving while BUSY is queued by its level and considered in the next IDLE. Both requests arriving in the same cycle resolve round-robin, so no port waits more than one other access.
- Reset mid-access: the arbiter returns to INIT immediately and drops any pending ack. init_done only returns high after mem_ready is seen high.
- Timeout: none. A stuck controller holds the arbiter in BUSY.

Test Plan:
- Reset release with mem_ready held 0 for 50 cycles, prg_req=1 -> no mem_req, no ack, init_done=0. mem_ready rises -> init_done=1 next cycle, then mem_req for PRG.
- PRG read, prg_addr=15'h7FFC, model returns 8'hA5 -> mem_address=21'h07FFC, mem_wren=0. prg_ack pulses once and prg_rdata=8'hA5.
- CHR read, chr_addr=13'h1FFF, CHR_BASE=21'h08000 -> mem_address=21'h09FFF, mem_wren=0. chr_rdata equals model data.
- prg_req and chr_req rise in the same cycle, both held -> order is PRG, CHR, PRG, CHR… Each ack lands on its own port and acks never overlap.
- PRG write, addr 15'h0010, wdata 8'h3C, while chr_rdata=8'h55 -> mem_wren=1, to_mem=8'h3C. prg_rdata and chr_rdata are unchanged.
- rst_n asserted in BUSY -> outputs are 0 immediately and no ack follows. After release, the arbiter re-enters INIT and waits for mem_ready.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares the single user port of the SDRAM controller between the PRG
// requester (CPU side, read/write) and the CHR requester (PPU side, read-only).
// Requests are held off until the controller first reports ready. The arbiter
// relocates CHR addresses to CHR_BASE, alternates grants round-robin when both
// ports contend, and returns read data on a per-port register.
module sdram_port_arbiter #(
    parameter int                ADDR_W   = 21,
    parameter int                PRG_AW   = 15,
    parameter int                CHR_AW   = 13,
    parameter logic [ADDR_W-1:0] CHR_BASE = 21'h08000
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              prg_req,
    input  logic              prg_wren,
    input  logic [PRG_AW-1:0] prg_addr,
    input  logic [7:0]        prg_wdata,
    output logic [7:0]        prg_rdata,
    output logic              prg_ack,

    input  logic              chr_req,
    input  logic [CHR_AW-1:0] chr_addr,
    output logic [7:0]        chr_rdata,
    output logic              chr_ack,

    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        to_mem,
    input  logic [7:0]        from_mem,
    output logic              mem_req,
    output logic              mem_wren,
    input  logic              mem_ready,
    output logic              init_done
);

    localparam logic [1:0] ST_INIT     = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_WAIT_LOW = 2'd2;
    localparam logic [1:0] ST_BUSY     = 2'd3;

    logic [1:0] state;
    logic       last_chr;   // 1 when the most recently completed access was CHR
    logic       grant_chr;  // port owning the access currently in flight
    logic       prg_pend;
    logic       chr_pend;
    logic       pick_chr;

    // CHR space lives at a fixed SDRAM offset; the sum wraps at ADDR_W bits.
    function automatic logic [ADDR_W-1:0] map_chr(input logic [CHR_AW-1:0] a);
        return CHR_BASE + ADDR_W'(a);
    endfunction

    function automatic logic [ADDR_W-1:0] map_prg(input logic [PRG_AW-1:0] a);
        return ADDR_W'(a);
    endfunction

    // Pending requests and round-robin pick. A port's req is ignored during its
    // own ack cycle, because that level still belongs to the access just served.
    always_comb begin
        prg_pend = prg_req & ~prg_ack;
        chr_pend = chr_req & ~chr_ack;
        pick_chr = chr_pend & (~prg_pend | ~last_chr);
    end

    // Arbitration FSM, controller handshake and per-port read data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            last_chr    <= 1'b1;
            grant_chr   <= 1'b0;
            init_done   <= 1'b0;
            mem_req     <= 1'b0;
            mem_wren    <= 1'b0;
            mem_address <= '0;
            to_mem      <= '0;
            prg_ack     <= 1'b0;
            chr_ack     <= 1'b0;
            prg_rdata   <= '0;
            chr_rdata   <= '0;
        end else begin
            mem_req <= 1'b0;
            prg_ack <= 1'b0;
            chr_ack <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (mem_ready) begin
                        init_done <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (mem_ready && (prg_pend || chr_pend)) begin
                        grant_chr <= pick_chr;
                        mem_req   <= 1'b1;
                        state     <= ST_WAIT_LOW;
                        if (pick_chr) begin
                            mem_address <= map_chr(chr_addr);
                            mem_wren    <= 1'b0;
                        end else begin
                            mem_address <= map_prg(prg_addr);
                            mem_wren    <= prg_wren;
                            to_mem      <= prg_wdata;
                        end
                    end
                end
                ST_WAIT_LOW: begin
                    if (!mem_ready) begin
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        if (grant_chr) begin
                            chr_rdata <= from_mem;
                            chr_ack   <= 1'b1;
                        end else begin
                            if (!mem_wren) begin
                                prg_rdata <= from_mem;
                            end
                            prg_ack <= 1'b1;
                        end
                        last_chr <= grant_chr;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter: a behavioural SDRAM controller with random
// busy times, a byte-addressed reference memory, and directed plus randomized
// PRG/CHR traffic checked against the address map, data and arbitration rules.
module tb_sdram_port_arbiter;

    localparam int          MEM_SZ   = 1 << 21;
    localparam logic [20:0] CHR_BASE = 21'h08000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prg_req, prg_wren, chr_req;
    logic [14:0] prg_addr;
    logic [12:0] chr_addr;
    logic [7:0]  prg_wdata, prg_rdata, chr_rdata, to_mem;
    logic [7:0]  from_mem = 8'h00;
    logic        prg_ack, chr_ack, mem_req, mem_wren, mem_ready, init_done;
    logic [20:0] mem_address;

    int          checks = 0;
    int          failures = 0;
    int          last_port;      // 0 = PRG, 1 = CHR completed last
    logic [7:0]  prg_shadow, chr_shadow;

    always #5 clk = ~clk;

    sdram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .prg_req(prg_req), .prg_wren(prg_wren), .prg_addr(prg_addr),
        .prg_wdata(prg_wdata), .prg_rdata(prg_rdata), .prg_ack(prg_ack),
        .chr_req(chr_req), .chr_addr(chr_addr), .chr_rdata(chr_rdata), .chr_ack(chr_ack),
        .mem_address(mem_address), .to_mem(to_mem), .from_mem(from_mem),
        .mem_req(mem_req), .mem_wren(mem_wren), .mem_ready(mem_ready),
        .init_done(init_done)
    );

    // Controller model state and storage
    logic        ctl_ready = 1'b1;
    logic        ctl_online = 1'b0;
    int          ctl_phase = 0;
    int          ctl_cnt = 0;
    int          ctl_busy_len = -1;
    logic [20:0] ctl_addr = '0;
    logic        ctl_we = 1'b0;
    logic [7:0]  ctl_wd = 8'h00;
    logic [7:0]  dev_mem [MEM_SZ];
    bit          dev_vld [MEM_SZ];
    logic [7:0]  ref_mem [MEM_SZ];
    bit          ref_vld [MEM_SZ];

    assign mem_ready = ctl_ready & ctl_online;

    // Initial SDRAM content (as if loaded from EEPROM)
    function automatic logic [7:0] fill(input logic [20:0] a);
        if (a == 21'h07FFC) return 8'hA5;
        if (a == 21'h08123) return 8'h55;
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] dev_rd(input logic [20:0] a);
        return dev_vld[a] ? dev_mem[a] : fill(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [20:0] a);
        return ref_vld[a] ? ref_mem[a] : fill(a);
    endfunction

    // Controller: drops ready 1 or 2 cycles after mem_req, stays busy, then
    // performs the access and raises ready with read data valid.
    always @(posedge clk) begin
        case (ctl_phase)
            0: begin
                if (mem_req) begin
                    ctl_addr <= mem_address;
                    ctl_we   <= mem_wren;
                    ctl_wd   <= to_mem;
                    if ($urandom_range(1, 0) == 0) begin
                        ctl_ready <= 1'b0;
                        ctl_cnt   <= (ctl_busy_len < 0) ? int'($urandom_range(3, 0)) : ctl_busy_len;
                        ctl_phase <= 2;
                    end else begin
                        ctl_phase <= 1;
                    end
                end
            end
            1: begin
                ctl_ready <= 1'b0;
                ctl_cnt   <= (ctl_busy_len < 0) ? int'($urandom_range(3, 0)) : ctl_busy_len;
                ctl_phase <= 2;
            end
            default: begin
                if (ctl_cnt == 0) begin
                    if (ctl_we) begin
                        dev_mem[ctl_addr] <= ctl_wd;
                        dev_vld[ctl_addr] <= 1'b1;
                    end else begin
                        from_mem <= dev_rd(ctl_addr);
                    end
                    ctl_ready <= 1'b1;
                    ctl_phase <= 0;
                end else begin
                    ctl_cnt <= ctl_cnt - 1;
                end
            end
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic prg_access(input logic wr, input logic [14:0] a, input logic [7:0] d,
                              output int waited);
        logic [20:0] ma;
        int n;
        ma = {6'b000000, a};
        prg_wren = wr; prg_addr = a; prg_wdata = d; prg_req = 1'b1;
        n = 0;
        do begin cyc(1); n++; end while (mem_req !== 1'b1 && n < 40);
        waited = n;
        chk("prg_grant", mem_req, 1'b1);
        chk("prg_mem_address", mem_address, ma);
        chk("prg_mem_wren", mem_wren, wr);
        if (wr) chk("prg_to_mem", to_mem, d);
        n = 0;
        do begin cyc(1); n++; end while (prg_ack !== 1'b1 && n < 80);
        chk("prg_ack", prg_ack, 1'b1);
        chk("prg_ack_other_quiet", chr_ack, 1'b0);
        if (wr) begin
            ref_mem[ma] = d;
            ref_vld[ma] = 1'b1;
        end else begin
            prg_shadow = ref_rd(ma);
        end
        chk("prg_rdata", prg_rdata, prg_shadow);
        chk("chr_rdata_held", chr_rdata, chr_shadow);
        last_port = 0;
        prg_req = 1'b0;
        cyc(1);
        chk("prg_ack_one_cycle", prg_ack, 1'b0);
        chk("prg_rdata_hold", prg_rdata, prg_shadow);
    endtask

    task automatic chr_access(input logic [12:0] a, output int waited);
        logic [20:0] ma;
        int n;
        ma = CHR_BASE + {8'h00, a};
        chr_addr = a; chr_req = 1'b1;
        n = 0;
        do begin cyc(1); n++; end while (mem_req !== 1'b1 && n < 40);
        waited = n;
        chk("chr_grant", mem_req, 1'b1);
        chk("chr_mem_address", mem_address, ma);
        chk("chr_mem_wren", mem_wren, 1'b0);
        n = 0;
        do begin cyc(1); n++; end while (chr_ack !== 1'b1 && n < 80);
        chk("chr_ack", chr_ack, 1'b1);
        chk("chr_ack_other_quiet", prg_ack, 1'b0);
        chr_shadow = ref_rd(ma);
        chk("chr_rdata", chr_rdata, chr_shadow);
        chk("prg_rdata_held", prg_rdata, prg_shadow);
        last_port = 1;
        chr_req = 1'b0;
        cyc(1);
        chk("chr_ack_one_cycle", chr_ack, 1'b0);
    endtask

    // Bus monitor: handshake legality, held request signals, ack timing
    initial begin
        logic        in_flight, exp_ack, rdy_prev, h_wren;
        logic [20:0] h_addr;
        logic [7:0]  h_wdata;
        in_flight = 1'b0; exp_ack = 1'b0; rdy_prev = 1'b0;
        h_wren = 1'b0; h_addr = '0; h_wdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_flight = 1'b0;
                exp_ack   = 1'b0;
                rdy_prev  = mem_ready;
            end else begin
                chk("ack_timing", prg_ack | chr_ack, exp_ack);
                chk("ack_overlap", prg_ack & chr_ack, 1'b0);
                if (in_flight) begin
                    chk("held_mem_address", mem_address, h_addr);
                    chk("held_mem_wren", mem_wren, h_wren);
                    chk("held_to_mem", to_mem, h_wdata);
                end
                if (prg_ack | chr_ack) in_flight = 1'b0;
                if (mem_req) begin
                    chk("req_while_ready", mem_ready, 1'b1);
                    chk("req_not_overlapping", in_flight, 1'b0);
                    in_flight = 1'b1;
                    h_addr = mem_address; h_wren = mem_wren; h_wdata = to_mem;
                end
                exp_ack  = in_flight & mem_ready & ~rdy_prev & ~mem_req;
                rdy_prev = mem_ready;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: no finish within time limit checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w, n, kind, acks, exp_port, port;
        logic [14:0] pa;
        logic [12:0] ca;

        prg_req = 1'b0; prg_wren = 1'b0; prg_addr = '0; prg_wdata = '0;
        chr_req = 1'b0; chr_addr = '0;
        prg_shadow = 8'h00; chr_shadow = 8'h00; last_port = 1;

        // Reset with a PRG request already pending; controller not ready yet
        rst_n = 1'b0;
        prg_addr = 15'h7FFC; prg_req = 1'b1;
        cyc(3);
        chk("reset_outputs_zero",
            {mem_req, mem_wren, mem_address, to_mem, prg_ack, chr_ack, prg_rdata, chr_rdata, init_done},
            64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            chk("init_hold_off", {mem_req, prg_ack, chr_ack, init_done}, 4'b0000);
        end
        ctl_online = 1'b1;
        cyc(1);
        chk("init_done_rise", init_done, 1'b1);
        chk("no_req_on_init_cycle", mem_req, 1'b0);
        prg_access(1'b0, 15'h7FFC, 8'h00, w);
        chk("prg_grant_after_init", w, 1);
        chk("prg_rdata_a5", prg_rdata, 8'hA5);

        // CHR read at the top of CHR space
        chr_access(13'h1FFF, w);
        chk("chr_uncontended_grant", w, 1);

        // PRG write must not disturb either read data register
        chr_access(13'h0123, w);
        chk("chr_rdata_55", chr_rdata, 8'h55);
        prg_access(1'b1, 15'h0010, 8'h3C, w);
        chk("chr_rdata_kept_55", chr_rdata, 8'h55);
        chk("prg_rdata_kept_after_write", prg_rdata, 8'hA5);
        prg_access(1'b0, 15'h0010, 8'h00, w);
        chk("prg_readback_3c", prg_rdata, 8'h3C);

        // Randomized single accesses over a small PRG window plus random CHR
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(2, 0));
            pa = 15'h0100 + 15'($urandom_range(7, 0));
            if (kind == 0)      prg_access(1'b0, pa, 8'h00, w);
            else if (kind == 1) prg_access(1'b1, pa, 8'($urandom), w);
            else                chr_access(13'($urandom), w);
            cyc(int'($urandom_range(2, 0)));
        end

        // Both ports held: grants must alternate starting opposite the last one
        pa = 15'h0100 + 15'($urandom_range(7, 0));
        ca = 13'($urandom);
        prg_wren = 1'b0; prg_addr = pa; chr_addr = ca;
        exp_port = 1 - last_port;
        prg_req = 1'b1; chr_req = 1'b1;
        acks = 0; n = 0;
        while (acks < 9 && n < 400) begin
            cyc(1); n++;
            if (prg_ack === 1'b1 || chr_ack === 1'b1) begin
                port = (chr_ack === 1'b1) ? 1 : 0;
                chk("rr_order", port, exp_port);
                if (port == 0) begin
                    prg_shadow = ref_rd({6'b000000, pa});
                    chk("rr_prg_rdata", prg_rdata, prg_shadow);
                    chk("rr_chr_held", chr_rdata, chr_shadow);
                end else begin
                    chr_shadow = ref_rd(CHR_BASE + {8'h00, ca});
                    chk("rr_chr_rdata", chr_rdata, chr_shadow);
                    chk("rr_prg_held", prg_rdata, prg_shadow);
                end
                acks++;
                last_port = port;
                exp_port = 1 - port;
                if (acks < 8) begin
                    if (port == 0) begin pa = 15'h0100 + 15'($urandom_range(7, 0)); prg_addr = pa; end
                    else begin ca = 13'($urandom); chr_addr = ca; end
                end else begin
                    if (port == 0) prg_req = 1'b0;
                    else chr_req = 1'b0;
                end
            end
        end
        chk("rr_all_acks", acks, 9);
        prg_req = 1'b0; chr_req = 1'b0;
        cyc(2);

        // Reset in the middle of a long CHR access
        ctl_busy_len = 20;
        chr_addr = 13'($urandom); chr_req = 1'b1;
        n = 0;
        do begin cyc(1); n++; end while (mem_req !== 1'b1 && n < 40);
        chk("rst_test_grant", mem_req, 1'b1);
        cyc(3);
        chk("rst_test_ctl_busy", mem_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_zero",
            {mem_req, mem_wren, mem_address, to_mem, prg_ack, chr_ack, prg_rdata, chr_rdata, init_done},
            64'd0);
        chr_req = 1'b0;
        prg_shadow = 8'h00; chr_shadow = 8'h00; last_port = 1;
        cyc(2);
        rst_n = 1'b1;
        n = 0;
        do begin
            cyc(1); n++;
            chk("reinit_hold", {init_done, prg_ack, chr_ack, mem_req}, 4'b0000);
        end while (mem_ready !== 1'b1 && n < 60);
        chk("reinit_ready_seen", mem_ready, 1'b1);
        ctl_busy_len = -1;
        cyc(1);
        chk("reinit_done", init_done, 1'b1);
        chk("rdata_cleared", {prg_rdata, chr_rdata}, 16'h0000);
        prg_access(1'b0, 15'h7FFC, 8'h00, w);
        chk("post_reset_prg_a5", prg_rdata, 8'hA5);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
